key_state_decoder: RTL and testbench

//  Turns the PS/2 scancode byte stream (set 2) from the PS/2 receiver into held-key

---
 rtl/key_state_decoder.sv | 185 ++++++++++++++++++
 tb/tb_key_state_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_state_decoder.sv
// key_state_decoder
//   Turns a PS/2 set-2 scancode byte stream into held-key levels for the
//   character movement FSM: left, right, up, down, jump, and a sticky
//   start_game flag. The E0 (extended) and F0 (break) prefixes are tracked by
//   a small FSM. Arrow keys and WASD are aliases of the same direction bit.
//
//   Handshake: a byte is consumed on each clock edge where rx_valid=1. There is
//   no backpressure. rx_err is only looked at while rx_valid=1. On an error the
//   byte is dropped and the FSM returns to ST_IDLE.
//
//   Optional feature, enabled with the macro KEY_WATCHDOG_EN: an idle
//   watchdog. After TIMEOUT_CYCLES cycles with no byte it releases every
//   movement key, so a lost break code cannot leave a key stuck down.
//
//   state_dbg shows the prefix FSM state: 0 idle, 1 ext, 2 break, 3 ext_break.
module key_state_decoder
`ifdef KEY_WATCHDOG_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = 32'd65_000_000
)
`endif
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic       left,
   output logic       right,
   output logic       up,
   output logic       down,
   output logic       jump,
   output logic       start_game,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_EXT       = 2'd1,
      ST_BREAK     = 2'd2,
      ST_EXT_BREAK = 2'd3
   } state_t;

   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_OVR0  = 8'h00;
   localparam logic [7:0] CODE_OVR1  = 8'hFF;
   localparam logic [7:0] CODE_ENTER = 8'h5A;

   // Key bit positions inside keys_q.
   localparam int K_LEFT  = 0;
   localparam int K_RIGHT = 1;
   localparam int K_UP    = 2;
   localparam int K_DOWN  = 3;
   localparam int K_JUMP  = 4;

   state_t     state_q, state_d;
   logic [4:0] keys_q, keys_d;
   logic       start_q, start_d;
   logic [4:0] mask_plain, mask_ext;
   logic       is_prefix, is_overrun, wd_fire;

   assign is_prefix  = (rx_data == CODE_EXT) || (rx_data == CODE_BRK);
   assign is_overrun = (rx_data == CODE_OVR0) || (rx_data == CODE_OVR1);

`ifdef KEY_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   // The watchdog fires only on the cycle the count reaches TIMEOUT_CYCLES.
   // A byte arriving on that same cycle wins over the timeout.
   assign wd_fire = !rx_valid && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // Idle counter: cleared by every byte, otherwise counts up and saturates.
   always_ff @(posedge clk) begin
      if (rst)
         wd_cnt <= '0;
      else if (rx_valid)
         wd_cnt <= '0;
      else if (wd_cnt != WD_W'(TIMEOUT_CYCLES))
         wd_cnt <= wd_cnt + 1'b1;
   end
`else
   assign wd_fire = 1'b0;
`endif

   // Scancode tables: plain codes are WASD and space; extended codes are the
   // arrow keys.
   always_comb begin
      mask_plain = '0;
      mask_ext   = '0;
      case (rx_data)
         8'h1C:   mask_plain[K_LEFT]  = 1'b1;
         8'h23:   mask_plain[K_RIGHT] = 1'b1;
         8'h1D:   mask_plain[K_UP]    = 1'b1;
         8'h1B:   mask_plain[K_DOWN]  = 1'b1;
         8'h29:   mask_plain[K_JUMP]  = 1'b1;
         8'h6B:   mask_ext[K_LEFT]    = 1'b1;
         8'h74:   mask_ext[K_RIGHT]   = 1'b1;
         8'h75:   mask_ext[K_UP]      = 1'b1;
         8'h72:   mask_ext[K_DOWN]    = 1'b1;
         default: ;
      endcase
   end

   // State register for the prefix FSM.
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next state: prefixes move the FSM forward, any other byte completes the
   // sequence. Error and overrun bytes always abort back to idle.
   always_comb begin
      state_d = state_q;
      if (rx_valid) begin
         if (rx_err || is_overrun) begin
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (rx_data == CODE_EXT)      state_d = ST_EXT;
                  else if (rx_data == CODE_BRK) state_d = ST_BREAK;
               end
               ST_EXT: begin
                  if (rx_data == CODE_BRK)      state_d = ST_EXT_BREAK;
                  else if (rx_data != CODE_EXT) state_d = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end else if (wd_fire) begin
         state_d = ST_IDLE;
      end
   end

   // Next key levels: a make code sets its bit and a break code clears it.
   // Overrun and watchdog release the movement keys but leave start_game set.
   always_comb begin
      keys_d  = keys_q;
      start_d = start_q;
      if (rx_valid) begin
         if (!rx_err) begin
            if (is_overrun) begin
               keys_d = '0;
            end else if (!is_prefix) begin
               case (state_q)
                  ST_IDLE: begin
                     keys_d = keys_q | mask_plain;
                     if (rx_data == CODE_ENTER) start_d = 1'b1;
                  end
                  ST_EXT:       keys_d = keys_q | mask_ext;
                  ST_BREAK:     keys_d = keys_q & ~mask_plain;
                  ST_EXT_BREAK: keys_d = keys_q & ~mask_ext;
                  default:      keys_d = keys_q;
               endcase
            end
         end
      end else if (wd_fire) begin
         keys_d = '0;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         keys_q  <= '0;
         start_q <= 1'b0;
      end else begin
         keys_q  <= keys_d;
         start_q <= start_d;
      end
   end

   assign left       = keys_q[K_LEFT];
   assign right      = keys_q[K_RIGHT];
   assign up         = keys_q[K_UP];
   assign down       = keys_q[K_DOWN];
   assign jump       = keys_q[K_JUMP];
   assign start_game = start_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_key_state_decoder.sv
// tb_key_state_decoder
//   Directed-vector bench for key_state_decoder. obs packs the outputs as
//   {start_game, jump, down, up, right, left}. Inputs change on the falling
//   edge and outputs are sampled on the falling edge after the rising edge
//   that consumed the byte. The watchdog scenario is built only when
//   KEY_WATCHDOG_EN is defined, using TIMEOUT_CYCLES=100.
module tb_key_state_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       left, right, up, down, jump, start_game;
   logic [1:0] state_dbg;
   logic [5:0] obs;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   assign obs = {start_game, jump, down, up, right, left};

`ifdef KEY_WATCHDOG_EN
   key_state_decoder #(.TIMEOUT_CYCLES(100)) dut (
`else
   key_state_decoder dut (
`endif
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_err     (rx_err),
      .left       (left),
      .right      (right),
      .up         (up),
      .down       (down),
      .jump       (jump),
      .start_game (start_game),
      .state_dbg  (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Driver: present one byte for exactly one rising edge, starting at a falling edge.
   task automatic send_byte(input logic [7:0] b, input logic e);
      rx_data  = b;
      rx_err   = e;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_err   = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (obs !== 6'b000000) begin miss_cnt++; $display("FAIL reset_keys: got %b want %b", obs, 6'b000000); end
      vec_cnt++;
      if (state_dbg !== 2'd0) begin miss_cnt++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
      rst = 1'b0;
   endtask

   task automatic test_start_game();
      send_byte(8'h5A, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL enter_make: got %b want %b", obs, 6'b100000); end
      send_byte(8'hF0, 1'b0);
      vec_cnt++;
      if (state_dbg !== 2'd2) begin miss_cnt++; $display("FAIL break_prefix_state: got %0d want 2", state_dbg); end
      send_byte(8'h5A, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL enter_break_sticky: got %b want %b", obs, 6'b100000); end
   endtask

   task automatic test_ext_left();
      send_byte(8'hE0, 1'b0);
      vec_cnt++;
      if (state_dbg !== 2'd1) begin miss_cnt++; $display("FAIL ext_prefix_state: got %0d want 1", state_dbg); end
      send_byte(8'h6B, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100001) begin miss_cnt++; $display("FAIL ext_left_make: got %b want %b", obs, 6'b100001); end
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      vec_cnt++;
      if (state_dbg !== 2'd3) begin miss_cnt++; $display("FAIL ext_break_state: got %0d want 3", state_dbg); end
      send_byte(8'h6B, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL ext_left_break: got %b want %b", obs, 6'b100000); end
   endtask

   task automatic test_alias();
      send_byte(8'h1C, 1'b0);
      send_byte(8'hE0, 1'b0);
      send_byte(8'h6B, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100001) begin miss_cnt++; $display("FAIL alias_both_held: got %b want %b", obs, 6'b100001); end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL alias_one_released: got %b want %b", obs, 6'b100000); end
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h6B, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL alias_second_break: got %b want %b", obs, 6'b100000); end
   endtask

   task automatic test_overrun();
      send_byte(8'h29, 1'b0);
      send_byte(8'hE0, 1'b0);
      send_byte(8'h74, 1'b0);
      vec_cnt++;
      if (obs !== 6'b110010) begin miss_cnt++; $display("FAIL jump_right: got %b want %b", obs, 6'b110010); end
      send_byte(8'hFF, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL overrun_ff: got %b want %b", obs, 6'b100000); end
      // Opposite keys both held, then a typematic repeat.
      send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
      send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
      send_byte(8'hE0, 1'b0); send_byte(8'h72, 1'b0);
      send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
      vec_cnt++;
      if (obs !== 6'b101111) begin miss_cnt++; $display("FAIL opposite_keys: got %b want %b", obs, 6'b101111); end
      send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
      vec_cnt++;
      if (obs !== 6'b101111) begin miss_cnt++; $display("FAIL typematic: got %b want %b", obs, 6'b101111); end
      send_byte(8'hE0, 1'b0);
      send_byte(8'h00, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL overrun_00: got %b want %b", obs, 6'b100000); end
      vec_cnt++;
      if (state_dbg !== 2'd0) begin miss_cnt++; $display("FAIL overrun_state: got %0d want 0", state_dbg); end
   endtask

   task automatic test_error_and_abort();
      send_byte(8'h29, 1'b0);
      send_byte(8'hE0, 1'b1);
      vec_cnt++;
      if (state_dbg !== 2'd0) begin miss_cnt++; $display("FAIL err_state: got %0d want 0", state_dbg); end
      send_byte(8'h6B, 1'b0);
      vec_cnt++;
      if (obs !== 6'b110000) begin miss_cnt++; $display("FAIL err_ext_dropped: got %b want %b", obs, 6'b110000); end
      // An errored break target must leave the key held.
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b1);
      vec_cnt++;
      if (obs !== 6'b110000) begin miss_cnt++; $display("FAIL err_keeps_keys: got %b want %b", obs, 6'b110000); end
      send_byte(8'hF0, 1'b0);
      send_byte(8'h29, 1'b0);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL jump_break: got %b want %b", obs, 6'b100000); end
      // Reset in the middle of an extended sequence.
      send_byte(8'hE0, 1'b0);
      pulse_rst();
      vec_cnt++;
      if (obs !== 6'b000000) begin miss_cnt++; $display("FAIL rst_clears_all: got %b want %b", obs, 6'b000000); end
      send_byte(8'h75, 1'b0);
      vec_cnt++;
      if (obs !== 6'b000000) begin miss_cnt++; $display("FAIL rst_aborts_ext: got %b want %b", obs, 6'b000000); end
      send_byte(8'hF0, 1'b0);
      send_byte(8'hE0, 1'b0);
      send_byte(8'h74, 1'b0);
      vec_cnt++;
      if (obs !== 6'b000000) begin miss_cnt++; $display("FAIL break_then_e0: got %b want %b", obs, 6'b000000); end
      vec_cnt++;
      if (state_dbg !== 2'd0) begin miss_cnt++; $display("FAIL break_then_e0_state: got %0d want 0", state_dbg); end
   endtask

   task automatic test_ignored_codes();
      send_byte(8'hE0, 1'b0);
      send_byte(8'h29, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hFA, 1'b0);
      vec_cnt++;
      if (obs !== 6'b000000) begin miss_cnt++; $display("FAIL ignored_codes: got %b want %b", obs, 6'b000000); end
      send_byte(8'hE0, 1'b0);
      send_byte(8'hE0, 1'b0);
      vec_cnt++;
      if (state_dbg !== 2'd1) begin miss_cnt++; $display("FAIL double_e0_state: got %0d want 1", state_dbg); end
      send_byte(8'h6B, 1'b0);
      vec_cnt++;
      if (obs !== 6'b000001) begin miss_cnt++; $display("FAIL double_e0_left: got %b want %b", obs, 6'b000001); end
      send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h6B, 1'b0);
   endtask

   task automatic test_back_to_back();
      send_byte(8'hF0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1D, 1'b0);
      vec_cnt++;
      if (obs !== 6'b000100) begin miss_cnt++; $display("FAIL double_f0_up: got %b want %b", obs, 6'b000100); end
      send_byte(8'h1B, 1'b0);
      send_byte(8'h23, 1'b0);
      vec_cnt++;
      if (obs !== 6'b001110) begin miss_cnt++; $display("FAIL wasd_burst: got %b want %b", obs, 6'b001110); end
      send_byte(8'hF0, 1'b0); send_byte(8'h1D, 1'b0);
      send_byte(8'hF0, 1'b0); send_byte(8'h1B, 1'b0);
      vec_cnt++;
      if (obs !== 6'b000010) begin miss_cnt++; $display("FAIL wasd_release: got %b want %b", obs, 6'b000010); end
      send_byte(8'hF0, 1'b0); send_byte(8'h23, 1'b0);
   endtask

   task automatic test_hold();
      send_byte(8'hE0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         rx_data = 8'($urandom_range(0, 255));
         rx_err  = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      rx_data = 8'h00; rx_err = 1'b0;
      vec_cnt++;
      if (state_dbg !== 2'd1) begin miss_cnt++; $display("FAIL hold_state: got %0d want 1", state_dbg); end
      send_byte(8'h72, 1'b0);
      vec_cnt++;
      if (obs !== 6'b001000) begin miss_cnt++; $display("FAIL hold_then_down: got %b want %b", obs, 6'b001000); end
      send_byte(8'hFF, 1'b0);
   endtask

`ifdef KEY_WATCHDOG_EN
   task automatic test_watchdog();
      pulse_rst();
      send_byte(8'h5A, 1'b0);
      send_byte(8'hE0, 1'b0);
      send_byte(8'h72, 1'b0);
      repeat (99) @(negedge clk);
      vec_cnt++;
      if (obs !== 6'b101000) begin miss_cnt++; $display("FAIL wd_before_timeout: got %b want %b", obs, 6'b101000); end
      @(negedge clk);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL wd_timeout: got %b want %b", obs, 6'b100000); end
      send_byte(8'hE0, 1'b0);
      send_byte(8'h72, 1'b0);
      repeat (99) @(negedge clk);
      send_byte(8'h29, 1'b0);
      vec_cnt++;
      if (obs !== 6'b111000) begin miss_cnt++; $display("FAIL wd_byte_wins: got %b want %b", obs, 6'b111000); end
      repeat (99) @(negedge clk);
      vec_cnt++;
      if (obs !== 6'b111000) begin miss_cnt++; $display("FAIL wd_restart: got %b want %b", obs, 6'b111000); end
      @(negedge clk);
      vec_cnt++;
      if (obs !== 6'b100000) begin miss_cnt++; $display("FAIL wd_second_timeout: got %b want %b", obs, 6'b100000); end
   endtask
`endif

   initial begin
      test_reset();
      test_start_game();
      test_ext_left();
      test_alias();
      test_overrun();
      test_error_and_abort();
      test_ignored_codes();
      test_back_to_back();
      test_hold();
`ifdef KEY_WATCHDOG_EN
      test_watchdog();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
